// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, flag bit
// positions, sequencer FSM states and a flag-packing helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_EQ  = 4'b1100;
    localparam logic [3:0] OP_LT  = 4'b1101;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_S = 3;
    localparam int FLG_E = 4;

    // Flags reported when the ALU never answered: error only.
    localparam logic [4:0] FLAGS_TIMEOUT = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } seq_state_e;

    function automatic logic [4:0] pack_flags(
        input logic e, input logic s, input logic v, input logic c, input logic z
    );
        logic [4:0] f;
        f        = 5'b00000;
        f[FLG_E] = e;
        f[FLG_S] = s;
        f[FLG_V] = v;
        f[FLG_C] = c;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the sequencer: registered storage, read/write pointers
// that wrap modulo DEPTH, and an occupancy count for full/empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Initiator for the start/ready ALU: queues host commands, issues them one at
// a time, guards each with a timeout. Optional error counter: ALU_SEQ_ERRCNT_EN.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_op,
    input  logic [N-1:0]   cmd_a,
    input  logic [N-1:0]   cmd_b,
    output logic           alu_start,
    output logic [3:0]     alu_opcode,
    output logic [N-1:0]   alu_A,
    output logic [N-1:0]   alu_B,
    input  logic           alu_ready,
    input  logic [2*N-1:0] alu_result,
    input  logic           alu_Z,
    input  logic           alu_C,
    input  logic           alu_V,
    input  logic           alu_S,
    input  logic           alu_E,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*N-1:0] rsp_result,
    output logic [4:0]     rsp_flags,
    output logic           rsp_timeout,
`ifdef ALU_SEQ_ERRCNT_EN
    output logic [7:0]     err_count,
`endif
    output logic           busy
);

    localparam int         FW      = 4 + 2 * N;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    seq_state_e     r_state;
    seq_state_e     w_state_nxt;
    logic           w_full;
    logic           w_empty;
    logic [FW-1:0]  w_head;
    logic           w_pop;
    logic           w_ld_ready;
    logic           w_ld_timeout;
    logic           w_rsp_hs;
    logic           w_cnt_hit;

    logic           r_alu_start;
    logic [3:0]     r_alu_opcode;
    logic [N-1:0]   r_alu_a;
    logic [N-1:0]   r_alu_b;
    logic [7:0]     r_wait_cnt;
    logic           r_rsp_valid;
    logic [2*N-1:0] r_rsp_result;
    logic [4:0]     r_rsp_flags;
    logic           r_rsp_timeout;

    alu_cmd_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (cmd_valid),
        .i_pop   (w_pop),
        .i_data  ({cmd_op, cmd_a, cmd_b}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign cmd_ready = !w_full;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign w_cnt_hit = (r_wait_cnt == TO_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle control strobes; a ready pulse beats the timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_ld_ready   = 1'b0;
        w_ld_timeout = 1'b0;
        w_rsp_hs     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_ready) begin
                    w_ld_ready  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_cnt_hit) begin
                    w_ld_timeout = 1'b1;
                    w_state_nxt  = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Issue registers: loaded on pop so they hold the command through ISSUE and beyond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_start  <= 1'b0;
            r_alu_opcode <= 4'b0000;
            r_alu_a      <= {N{1'b0}};
            r_alu_b      <= {N{1'b0}};
        end else begin
            r_alu_start <= w_pop;
            if (w_pop) begin
                r_alu_opcode <= w_head[FW-1 -: 4];
                r_alu_a      <= w_head[2*N-1 -: N];
                r_alu_b      <= w_head[N-1:0];
            end
        end
    end

    // Wait-cycle counter, cleared while the start pulse is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'h00;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= 8'h00;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'h01;
        end
    end

    // Response channel: fields only change on entry to RESP, so they are stable until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= {(2*N){1'b0}};
            r_rsp_flags   <= 5'b00000;
            r_rsp_timeout <= 1'b0;
        end else if (w_ld_ready) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_result  <= alu_result;
            r_rsp_flags   <= pack_flags(alu_E, alu_S, alu_V, alu_C, alu_Z);
            r_rsp_timeout <= 1'b0;
        end else if (w_ld_timeout) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_result  <= {(2*N){1'b0}};
            r_rsp_flags   <= FLAGS_TIMEOUT;
            r_rsp_timeout <= 1'b1;
        end else if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_ERRCNT_EN
    logic [7:0] r_err_count;

    // Saturating count of accepted responses carrying the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'h00;
        end else if (w_rsp_hs && r_rsp_flags[FLG_E] && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    assign err_count = r_err_count;
`endif

    assign alu_start   = r_alu_start;
    assign alu_opcode  = r_alu_opcode;
    assign alu_A       = r_alu_a;
    assign alu_B       = r_alu_b;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_flags   = r_rsp_flags;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that acts as the initiator for the team's start/ready ALU. It accepts queued operation requests from a host over a valid/ready interface and buffers them in a small FIFO. It issues each request to the ALU as a one-cycle `alu_start` pulse, waits for the ALU's one-cycle `alu_ready` pulse, and returns result plus flags on a valid/ready response channel. A timeout guards against a hung ALU. It sits between the datapath controller and the ALU instance.

## Interface
- `N`, 8: operand width; must match the ALU's `N`.
- `DEPTH`, 4: command FIFO entries, power of two, ≥2.
- `TIMEOUT`, 15: maximum WAIT cycles before abandoning an operation, 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host request valid.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_op`  in  4  ALU opcode.
- `cmd_a`, `cmd_b`  in  N  signed operands.
- `alu_start`  out  1  one-cycle issue pulse to ALU.
- `alu_opcode`  out  4  opcode to ALU.
- `alu_A`, `alu_B`  out  N  operands to ALU.
- `alu_ready`  in  1  ALU completion pulse.
- `alu_result`  in  2N  ALU result.
- `alu_Z`, `alu_C`, `alu_V`, `alu_S`, `alu_E`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  host accepts response.
- `rsp_result`  out  2N  captured result.
- `rsp_flags`  out  5  {E,S,V,C,Z}, bit4 = E.
- `rsp_timeout`  out  1  response produced by timeout.
- `busy`  out  1  state ≠ IDLE or FIFO not empty.
- `err_count`  out  8  only with `ALU_SEQ_ERRCNT_EN`.

## Operation
- Command push on `cmd_valid && cmd_ready`. `cmd_ready = !full`, independent of same-cycle pop. Push and pop in the same cycle are both legal; the count is unchanged. Pointers wrap modulo `DEPTH`.
- FSM states are IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO is non-empty, pop the head into the `alu_opcode`/`alu_A`/`alu_B` registers and go to ISSUE.
  - ISSUE: `alu_start=1` for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: the counter increments each cycle. On `alu_ready`, capture `alu_result` and the flags, set `rsp_timeout=0`, and go to RESP. If the counter reaches `TIMEOUT` without `alu_ready`, set result to 0, `rsp_flags=5'b10000`, `rsp_timeout=1`, and go to RESP. `alu_ready` takes priority if both occur in the same cycle.
  - RESP: `rsp_valid=1`, with response fields held stable until `rsp_ready`. On handshake, go to IDLE.
- Only one operation is outstanding. `alu_ready` outside WAIT is ignored. A late pulse from a timed-out operation is not filtered; this is a documented limitation.
- `alu_opcode`/`alu_A`/`alu_B` hold their last issued values outside ISSUE.

## Timing
- Reset values:
  - `alu_start`, `rsp_valid`, `rsp_timeout`, `busy`, `err_count`: 0.
  - `rsp_result`, `rsp_flags`, `alu_opcode`, `alu_A`, `alu_B`: 0.
  - FIFO: empty, so `cmd_ready=1`.
  - FSM: IDLE.
- Reset asserted mid-operation aborts everything: queued commands are lost and a pending response is dropped.
- With the team ALU (capture on start, ready two edges later):
  - Push at edge 0 → IDLE pop at edge 1 → `alu_start` high in cycle 1–2 → `alu_ready` in cycle 3–4 → `rsp_valid` from cycle 4–5.
  - First `rsp_valid` is 4 cycles after the push edge.
  - Back-to-back throughput is one command per 5 cycles when `rsp_ready` is held high.
- Timeout response: `rsp_valid` rises exactly `TIMEOUT+1` cycles after the `alu_start` cycle.
- All outputs are registered except `cmd_ready` and `busy`.

## Configuration
- `ALU_SEQ_ERRCNT_EN` defined:
  - An 8-bit `err_count` increments, saturating at 255, on each RESP handshake with `rsp_flags[4]=1` (this includes timeouts).
  - Cleared only by reset.
- `ALU_SEQ_ERRCNT_EN` undefined: the `err_count` port and its logic are absent.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams 4'b0000–4'b1101 (ADD … LT).
  - Flag bit indices `FLG_Z=0` … `FLG_E=4`.
  - FSM state enum.
- Sub-module `alu_cmd_fifo`:
  - Parameters: width `4+2N`, `DEPTH`.
  - Ports: push/pop, full/empty, head data.
  - Registered storage with pointer + count.

## Test plan
- Push ADD, a=100, b=50, against a real ALU instance (`N=8`) → `rsp_result=16'hFF96`, `rsp_flags=5'b01100`, `rsp_timeout=0`, `rsp_valid` 4 cycles after the push.
- Push MUL −3×7, then DIV 10/0, back to back → responses in order: `16'hFFEB` with flags `5'b01000`, then `16'h0000` with flags `5'b10001`; exactly one `alu_start` pulse per command.
- Stub ALU never asserts ready, `TIMEOUT=15` → `rsp_timeout=1`, result 0, flags `5'b10000`, `rsp_valid` 16 cycles after `alu_start`. With the macro defined, `err_count=1` after the handshake.
- Hold `rsp_ready=0` and push 6 commands → 5 accepted (1 in flight, 4 queued), `cmd_ready=0` on the 6th. Releasing `rsp_ready` drains all 5 in order.
- Assert `rst_n=0` during WAIT with 2 commands queued → all outputs return to reset values, FIFO empty, no response is emitted after release.
- Inject a stray `alu_ready` in IDLE and in RESP → no state change; held `rsp_result` is unchanged.
